multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the 4-bit-opcode datapath (R, addi, andi, ori, nori, slti, beq, bne, lw, sw).
- Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Shares one variable-latency memory port between instruction fetch and data access via a req/ready handshake.
- Drives the datapath enables and muxes, replacing the single-cycle decoder.

Parameters:
- OPCODE_W, 4, opcode width.
- ALUOP_W, 3, ALU operation code width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  opcode field of the instruction register, valid from DECODE on.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current request.
- mem_req  out  1  memory request.
- mem_we  out  1  write request (1) or read request (0).
- ir_write  out  1  load the instruction register.
- pc_write  out  1  update the PC.
- pc_src  out  1  PC source: 0 = PC+4, 1 = branch target.
- alu_src  out  1  ALU B input: 0 = register, 1 = immediate.
- imm_type  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend.
- alu_op  out  ALUOP_W  ALU operation.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination register: 1 = rd, 0 = rt.
- mem_to_reg  out  1  writeback data: 1 = memory, 0 = ALU.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- halted  out  1  controller is halted (see Optional Feature).

Behaviour:
- State is registered. Outputs decode from state; the exceptions are pc_write and ir_write, which are gated as described below.
- Reset: async assert forces state INIT. All outputs are 0 during reset and in INIT. Reset mid-instruction abandons it; no pending writes occur.
- INIT -> FETCH unconditionally.
- FETCH:
  - mem_req=1, mem_we=0, held until mem_ready=1.
  - On the mem_ready cycle: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - If mem_ready stays 0, the controller waits indefinitely.
- DECODE:
  - One cycle; the branch target is computed here.
  - Opcodes 0000 and 0001-0100, 0111 go to EXEC.
  - Opcodes 0101 and 0110 go to BRANCH.
  - Opcodes 1000 and 1001 go to MEM_ADDR.
  - Opcodes 1010-1111 are illegal; see Optional Feature.
- EXEC: alu_src=0 for R, otherwise 1. alu_op per the table below. imm_type=1 for andi, ori, nori. Next state WB.
- WB: reg_write=1, reg_dst=1 for R only, mem_to_reg=0, instr_done=1. Next state FETCH.
- BRANCH:
  - alu_src=0, alu_op=101.
  - pc_write=zero for beq, or ~zero for bne; pc_src=1.
  - instr_done=1. Next state FETCH.
- MEM_ADDR: alu_src=1, alu_op=111. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, mem_we=0, waits on mem_ready, then MEM_WB.
- MEM_WR: mem_req=1, mem_we=1, waits on mem_ready, then instr_done=1 and FETCH.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next state FETCH.
- alu_op table: R=000, addi=001, andi=010, ori=011, nori=100, beq/bne=101, slti=110, lw/sw=111. The ALU decodes funct for R.
- Handshake:
  - mem_req and mem_we are stable while waiting.
  - A request completes on the first rising edge at which mem_req and mem_ready are both 1.
  - mem_ready while mem_req=0 is ignored.
  - The port is never requested in any other state.
- Minimum cycles with zero-wait memory (mem_ready=1 throughout):
  - R/I: 4 (FETCH, DECODE, EXEC, WB).
  - branch: 3.
  - sw: 4.
  - lw: 5.
- Each extra wait cycle adds 1.
- opcode is sampled only in DECODE and later; changes during FETCH are ignored.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- With the macro: an illegal opcode in DECODE moves to HALT. In HALT, halted=1, all other outputs are 0, and the controller stays there until rst_n is asserted.
- Without the macro: an illegal opcode is a NOP. DECODE goes to FETCH with instr_done=1, and halted is tied to 0.

Decomposition:
- Package mc_pkg holds:
  - opcode localparams (OP_R, OP_ADDI, ..., OP_SW).
  - ALU-op localparams (ALU_ADD=001, etc.).
  - state encoding (S_INIT, S_FETCH, S_DECODE, S_EXEC, S_WB, S_BRANCH, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_MEM_WB, S_HALT).
- One sub-module, mc_opcode_class: combinational. Maps opcode to class flags is_r, is_imm, is_branch, is_mem, is_illegal, plus the alu_op value.

Test Plan:
- add R (0000), mem_ready=1 always -> states INIT, FETCH, DECODE, EXEC, WB. reg_write=1 with reg_dst=1 in cycle 4 after FETCH entry; instr_done pulses once.
- lw (1000), mem_ready low 3 cycles in MEM_RD -> mem_req=1, mem_we=0 held 4 cycles. MEM_WB follows with mem_to_reg=1, reg_dst=0; 8 cycles total.
- beq (0101) with zero=1, then with zero=0 -> pc_write=1 with pc_src=1 in BRANCH, then pc_write=0 in BRANCH.
- bne (0110) with zero=0 -> pc_write=1 with pc_src=1; sw (1001) -> mem_we=1 in MEM_WR, reg_write never asserted.
- Opcode 1100 -> with MC_ILLEGAL_TRAP_EN, halted=1 and stays; without it, FETCH follows after 2 cycles with instr_done=1.
- rst_n low during MEM_WR wait -> outputs 0 immediately. After release: INIT, then FETCH, mem_req=1, no write issued.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, ALU operations, FSM states.
package mc_pkg;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_ORI  = 4'b0011;
  localparam logic [3:0] OP_NORI = 4'b0100;
  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [3:0] OP_BNE  = 4'b0110;
  localparam logic [3:0] OP_SLTI = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;

  localparam logic [2:0] ALU_FUNCT = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_NOR   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b110;
  localparam logic [2:0] ALU_ADDR  = 3'b111;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_BRANCH,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_MEM_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Shared memory port handshake: the controller issues req/we, memory answers with ready.
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier: class flags plus the ALU operation for EXEC.
module mc_opcode_class
  import mc_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic                is_r,
  output logic                is_imm,
  output logic                is_branch,
  output logic                is_mem,
  output logic                is_illegal,
  output logic                is_bne,
  output logic                is_sw,
  output logic                imm_zext,
  output logic [ALUOP_W-1:0]  alu_op
);

  always_comb begin
    is_r       = 1'b0;
    is_imm     = 1'b0;
    is_branch  = 1'b0;
    is_mem     = 1'b0;
    is_illegal = 1'b0;
    is_bne     = 1'b0;
    is_sw      = 1'b0;
    imm_zext   = 1'b0;
    alu_op     = '0;
    case (opcode)
      OP_R:    begin is_r = 1'b1;                     alu_op = ALUOP_W'(ALU_FUNCT); end
      OP_ADDI: begin is_imm = 1'b1;                   alu_op = ALUOP_W'(ALU_ADD);   end
      OP_ANDI: begin is_imm = 1'b1; imm_zext = 1'b1;  alu_op = ALUOP_W'(ALU_AND);   end
      OP_ORI:  begin is_imm = 1'b1; imm_zext = 1'b1;  alu_op = ALUOP_W'(ALU_OR);    end
      OP_NORI: begin is_imm = 1'b1; imm_zext = 1'b1;  alu_op = ALUOP_W'(ALU_NOR);   end
      OP_SLTI: begin is_imm = 1'b1;                   alu_op = ALUOP_W'(ALU_SLT);   end
      OP_BEQ:  begin is_branch = 1'b1;                alu_op = ALUOP_W'(ALU_SUB);   end
      OP_BNE:  begin is_branch = 1'b1; is_bne = 1'b1; alu_op = ALUOP_W'(ALU_SUB);   end
      OP_LW:   begin is_mem = 1'b1;                   alu_op = ALUOP_W'(ALU_ADDR);  end
      OP_SW:   begin is_mem = 1'b1; is_sw = 1'b1;     alu_op = ALUOP_W'(ALU_ADDR);  end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer sharing one memory port between fetch and data access.
// Build option MC_ILLEGAL_TRAP_EN: illegal opcodes halt the controller instead of retiring as NOPs.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 zero,
  multicycle_control_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 alu_src,
  output logic                 imm_type,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 instr_done,
  output logic                 halted
);

  state_t state_q, state_d;

  logic               cls_r, cls_imm, cls_branch, cls_mem, cls_illegal, cls_bne, cls_sw, cls_zext;
  logic [ALUOP_W-1:0] cls_alu_op;

  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic               pc_src_q, pc_src_d;
  logic               alu_src_q, alu_src_d;
  logic               imm_type_q, imm_type_d;
  logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
  logic               reg_write_q, reg_write_d;
  logic               reg_dst_q, reg_dst_d;
  logic               mem_to_reg_q, mem_to_reg_d;
  logic               instr_done_q, instr_done_d;

  mc_opcode_class #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_class (
    .opcode     (opcode),
    .is_r       (cls_r),
    .is_imm     (cls_imm),
    .is_branch  (cls_branch),
    .is_mem     (cls_mem),
    .is_illegal (cls_illegal),
    .is_bne     (cls_bne),
    .is_sw      (cls_sw),
    .imm_zext   (cls_zext),
    .alu_op     (cls_alu_op)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:     state_d = S_FETCH;
      S_FETCH:    if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (cls_illegal) begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end else if (cls_branch) state_d = S_BRANCH;
        else if (cls_mem)        state_d = S_MEM_ADDR;
        else                     state_d = S_EXEC;
      end
      S_EXEC:     state_d = S_WB;
      S_WB:       state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_MEM_ADDR: state_d = cls_sw ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem.mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem.mem_ready) state_d = S_FETCH;
      S_MEM_WB:   state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_INIT;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered on state entry;
  // the opcode is stable from DECODE onward, so EXEC/WB fields can use it here.
  always_comb begin
    mem_req_d    = (state_d == S_FETCH) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
    mem_we_d     = (state_d == S_MEM_WR);
    pc_src_d     = (state_d == S_BRANCH);
    alu_src_d    = ((state_d == S_EXEC) && cls_imm) || (state_d == S_MEM_ADDR);
    imm_type_d   = (state_d == S_EXEC) && cls_zext;
    alu_op_d     = '0;
    if (state_d == S_EXEC)     alu_op_d = cls_alu_op;
    if (state_d == S_BRANCH)   alu_op_d = ALUOP_W'(ALU_SUB);
    if (state_d == S_MEM_ADDR) alu_op_d = ALUOP_W'(ALU_ADDR);
    reg_write_d  = (state_d == S_WB) || (state_d == S_MEM_WB);
    reg_dst_d    = (state_d == S_WB) && cls_r;
    mem_to_reg_d = (state_d == S_MEM_WB);
    instr_done_d = (state_d == S_WB) || (state_d == S_MEM_WB) || (state_d == S_BRANCH);
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic halted_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      pc_src_q     <= 1'b0;
      alu_src_q    <= 1'b0;
      imm_type_q   <= 1'b0;
      alu_op_q     <= '0;
      reg_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      instr_done_q <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
      halted_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      pc_src_q     <= pc_src_d;
      alu_src_q    <= alu_src_d;
      imm_type_q   <= imm_type_d;
      alu_op_q     <= alu_op_d;
      reg_write_q  <= reg_write_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      instr_done_q <= instr_done_d;
`ifdef MC_ILLEGAL_TRAP_EN
      halted_q     <= (state_d == S_HALT);
`endif
    end
  end

  assign mem.mem_req = mem_req_q;
  assign mem.mem_we  = mem_we_q;
  assign pc_src      = pc_src_q;
  assign alu_src     = alu_src_q;
  assign imm_type    = imm_type_q;
  assign alu_op      = alu_op_q;
  assign reg_write   = reg_write_q;
  assign reg_dst     = reg_dst_q;
  assign mem_to_reg  = mem_to_reg_q;

  // Completion-dependent strobes are gated by the live handshake / flag in the current state.
  assign ir_write = (state_q == S_FETCH) && mem.mem_ready;
  assign pc_write = ir_write || ((state_q == S_BRANCH) && (cls_bne ? !zero : zero));

`ifdef MC_ILLEGAL_TRAP_EN
  assign instr_done = instr_done_q || ((state_q == S_MEM_WR) && mem.mem_ready);
  assign halted     = halted_q;
`else
  assign instr_done = instr_done_q || ((state_q == S_MEM_WR) && mem.mem_ready)
                      || ((state_q == S_DECODE) && cls_illegal);
  assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle drive/expect entries are queued per instruction.
module tb_multicycle_control;
  import mc_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       alu_src;
    logic       imm_type;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       halted;
  } outv_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
  } drv_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero;
  logic       ir_write, pc_write, pc_src, alu_src, imm_type;
  logic [2:0] alu_op;
  logic       reg_write, reg_dst, mem_to_reg, instr_done, halted;
  outv_t      act;

  int n_checks = 0;
  int n_pass   = 0;

  drv_t  drv_q[$];
  outv_t exp_q[$];
  string tag_q[$];

  multicycle_control_if mem_if();

  multicycle_control #(
    .OPCODE_W (4),
    .ALUOP_W  (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem        (mem_if),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src    (alu_src),
    .imm_type   (imm_type),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .instr_done (instr_done),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  assign act = {mem_if.mem_req, mem_if.mem_we, ir_write, pc_write, pc_src, alu_src, imm_type,
                alu_op, reg_write, reg_dst, mem_to_reg, instr_done, halted};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input logic [3:0] op, input logic zr, input logic rdy,
                      input outv_t e);
    drv_t d;
    d.opcode    = op;
    d.zero      = zr;
    d.mem_ready = rdy;
    drv_q.push_back(d);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Expected per-cycle trace of one instruction, starting at FETCH entry.
  task automatic push_instr(input logic [3:0] op, input logic zr, input int wf, input int wm,
                            input bit hang);
    outv_t e;
    string nm;
    logic  is_r, is_br, is_ld, is_st, bad;
    logic [2:0] aop;
    nm    = $sformatf("op%h", op);
    is_r  = (op == 4'h0);
    is_br = (op == 4'h5) || (op == 4'h6);
    is_ld = (op == 4'h8);
    is_st = (op == 4'h9);
    bad   = (op >= 4'ha);
    case (op)
      4'h0: aop = 3'b000;
      4'h1: aop = 3'b001;
      4'h2: aop = 3'b010;
      4'h3: aop = 3'b011;
      4'h4: aop = 3'b100;
      4'h5, 4'h6: aop = 3'b101;
      4'h7: aop = 3'b110;
      default: aop = 3'b111;
    endcase
    for (int i = 0; i < wf; i++) begin
      e = '0; e.mem_req = 1'b1;
      push({nm, "_fetch_wait"}, 4'($urandom), 1'($urandom), 1'b0, e);
    end
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    push({nm, "_fetch"}, 4'($urandom), 1'($urandom), 1'b1, e);
    e = '0;
`ifndef MC_ILLEGAL_TRAP_EN
    if (bad) e.instr_done = 1'b1;
`endif
    push({nm, "_decode"}, op, 1'($urandom), 1'($urandom), e);
    if (bad) begin
`ifdef MC_ILLEGAL_TRAP_EN
      for (int i = 0; i < 4; i++) begin
        e = '0; e.halted = 1'b1;
        push({nm, "_halt"}, op, 1'($urandom), 1'($urandom), e);
      end
`endif
    end else if (is_br) begin
      e = '0; e.alu_op = 3'b101; e.pc_src = 1'b1; e.instr_done = 1'b1;
      e.pc_write = (op == 4'h5) ? zr : !zr;
      push({nm, "_branch"}, op, zr, 1'($urandom), e);
    end else if (is_ld || is_st) begin
      e = '0; e.alu_src = 1'b1; e.alu_op = 3'b111;
      push({nm, "_mem_addr"}, op, 1'($urandom), 1'($urandom), e);
      for (int i = 0; i < wm; i++) begin
        e = '0; e.mem_req = 1'b1; e.mem_we = is_st;
        push({nm, "_mem_wait"}, op, 1'($urandom), 1'b0, e);
      end
      if (!hang) begin
        e = '0; e.mem_req = 1'b1; e.mem_we = is_st; e.instr_done = is_st;
        push({nm, "_mem_done"}, op, 1'($urandom), 1'b1, e);
        if (is_ld) begin
          e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
          push({nm, "_mem_wb"}, op, 1'($urandom), 1'($urandom), e);
        end
      end
    end else begin
      e = '0; e.alu_src = !is_r; e.alu_op = aop;
      e.imm_type = (op == 4'h2) || (op == 4'h3) || (op == 4'h4);
      push({nm, "_exec"}, op, 1'($urandom), 1'($urandom), e);
      e = '0; e.reg_write = 1'b1; e.reg_dst = is_r; e.instr_done = 1'b1;
      push({nm, "_wb"}, op, 1'($urandom), 1'($urandom), e);
    end
  endtask

  task automatic run_queue();
    drv_t  d;
    outv_t e;
    string t;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      d = drv_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      opcode           = d.opcode;
      zero             = d.zero;
      mem_if.mem_ready = d.mem_ready;
      #1;
      check_val(t, 32'(act), 32'(e));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n            = 1'b0;
    opcode           = 4'h0;
    zero             = 1'b0;
    mem_if.mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check_val("reset_outputs", 32'(act), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("init_outputs", 32'(act), 32'd0);

    push_instr(4'h0, 1'b0, 0, 0, 1'b0);
    push_instr(4'h1, 1'b0, 2, 0, 1'b0);
    push_instr(4'h2, 1'b0, 0, 0, 1'b0);
    push_instr(4'h3, 1'b0, 1, 0, 1'b0);
    push_instr(4'h4, 1'b0, 0, 0, 1'b0);
    push_instr(4'h7, 1'b0, 0, 0, 1'b0);
    push_instr(4'h5, 1'b1, 0, 0, 1'b0);
    push_instr(4'h5, 1'b0, 0, 0, 1'b0);
    push_instr(4'h6, 1'b0, 0, 0, 1'b0);
    push_instr(4'h6, 1'b1, 1, 0, 1'b0);
    push_instr(4'h8, 1'b0, 0, 3, 1'b0);
    push_instr(4'h8, 1'b0, 0, 0, 1'b0);
    push_instr(4'h9, 1'b0, 0, 0, 1'b0);
    push_instr(4'h9, 1'b0, 2, 2, 1'b0);
    push_instr(4'h9, 1'b0, 0, 3, 1'b1);
    run_queue();

    // Reset lands while the store is still waiting for memory.
    #2;
    rst_n = 1'b0;
    #1;
    check_val("reset_async_outputs", 32'(act), 32'd0);
    @(negedge clk); #1;
    check_val("reset_held_outputs", 32'(act), 32'd0);
    rst_n = 1'b1;
    mem_if.mem_ready = 1'b1;
    #1;
    check_val("init_after_reset", 32'(act), 32'd0);

    push_instr(4'h1, 1'b0, 0, 0, 1'b0);
    push_instr(4'hc, 1'b0, 0, 0, 1'b0);
`ifndef MC_ILLEGAL_TRAP_EN
    push_instr(4'h0, 1'b0, 0, 0, 1'b0);
`endif
    run_queue();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
